// File: rtl/irq_ctrl_pkg.sv
// Register map and field positions shared by the external interrupt controller.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IRQ_PENDING = 2'd0,
    IRQ_MASK    = 2'd1,
    IRQ_MODE    = 2'd2,
    IRQ_CAUSE   = 2'd3
  } irq_reg_e;

  localparam int IRQ_CAUSE_INSVC = 31;
  localparam int IRQ_REG_W       = 32;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser per interrupt line plus a history flop for rising-edge detect.
module irq_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] s2_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign s2_o   = s2_q;
  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller feeding CP0 ir_in: pending/mask/mode registers,
// lowest-index priority, and an in-service interlock released by ERET.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC  = 8,
  parameter int                 ID_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter logic [NUM_SRC-1:0] MODE_RST = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   irq_src,
  output logic                 ir_out,
  input  logic                 irq_ack,
  input  logic                 eret,
  output logic [ID_W-1:0]      irq_id,
  input  logic                 reg_we,
  input  logic [1:0]           reg_addr,
  input  logic [IRQ_REG_W-1:0] reg_wdata,
  output logic [IRQ_REG_W-1:0] reg_rdata
);

  logic [NUM_SRC-1:0]   s2;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic [NUM_SRC-1:0]   mode_q, mode_d;
  logic                 in_service_q, in_service_d;
  logic                 ir_out_q, ir_out_d;
  logic [ID_W-1:0]      irq_id_q, irq_id_d;
  logic [IRQ_REG_W-1:0] rdata_q, rdata_d;

  logic [NUM_SRC-1:0]   masked;
  logic [NUM_SRC-1:0]   win_onehot;
  logic [NUM_SRC-1:0]   w1c;
  logic [NUM_SRC-1:0]   clr;
  logic [NUM_SRC-1:0]   wr_val;
  logic                 ack_accept;
  irq_reg_e             sel;
  wire                  unused_wdata = &{1'b0, reg_wdata};

  irq_sync #(.W(NUM_SRC)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(irq_src),
    .s2_o   (s2),
    .rise_o (rise)
  );

  // Lowest set index wins; an empty vector encodes as 0.
  function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_SRC-1:0] v);
    prio_enc = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) prio_enc = ID_W'(i);
    end
  endfunction

  assign sel        = irq_reg_e'(reg_addr);
  assign wr_val     = reg_wdata[NUM_SRC-1:0];
  assign masked     = pending_q & mask_q;
  assign win_onehot = masked & (~masked + NUM_SRC'(1));
  assign ack_accept = irq_ack & ir_out_q;
  assign w1c        = (reg_we && sel == IRQ_PENDING) ? wr_val : '0;
  assign clr        = w1c | (ack_accept ? win_onehot : '0);

  always_comb begin
    // Edge lines: a same-cycle rise beats any clear. Level lines mirror s2.
    pending_d    = (mode_q & (rise | (pending_q & ~clr))) | (~mode_q & s2);
    mask_d       = mask_q;
    mode_d       = mode_q;
    in_service_d = in_service_q;
    irq_id_d     = irq_id_q;
    ir_out_d     = (|masked) & ~in_service_q & ~ack_accept;
    rdata_d      = '0;

    if (reg_we && sel == IRQ_MASK) mask_d = wr_val;
    if (reg_we && sel == IRQ_MODE) mode_d = wr_val;

    if (ack_accept) begin
      in_service_d = 1'b1;
      irq_id_d     = prio_enc(masked);
    end else if (eret) begin
      in_service_d = 1'b0;
    end

    case (sel)
      IRQ_PENDING: rdata_d[NUM_SRC-1:0] = pending_q;
      IRQ_MASK:    rdata_d[NUM_SRC-1:0] = mask_q;
      IRQ_MODE:    rdata_d[NUM_SRC-1:0] = mode_q;
      IRQ_CAUSE: begin
        rdata_d[IRQ_CAUSE_INSVC] = in_service_q;
        rdata_d[ID_W-1:0]        = irq_id_q;
      end
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      mask_q       <= '0;
      mode_q       <= MODE_RST;
      in_service_q <= 1'b0;
      ir_out_q     <= 1'b0;
      irq_id_q     <= '0;
      rdata_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      in_service_q <= in_service_d;
      ir_out_q     <= ir_out_d;
      irq_id_q     <= irq_id_d;
      rdata_q      <= rdata_d;
    end
  end

  assign ir_out    = ir_out_q;
  assign irq_id    = irq_id_q;
  assign reg_rdata = rdata_q;

endmodule
